// File: rtl/frame_buf_ctrl_pkg.sv
// Shared encodings and helpers for the frame buffer ring controller.
// Holds widths, FSM state constants and the buffer address helper.
// No logic of its own; imported by the controller and its sequence RAM.
package frame_buf_ctrl_pkg;

  localparam int MAX_BUFFERS = 8;
  localparam int MAX_IDX_W   = 3;
  localparam int ADDR_W      = 30;
  localparam int SEQ_W       = 16;

  // Capture FSM states
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CAPTURE = 1'b1;

  // Read FSM states
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_BUSY = 1'b1;

  // Ownership of a single ring slot. Not stored: it is implied by
  // rd_idx, wr_idx, frames_ready, reading and capturing.
  typedef enum logic [1:0] {
    BUF_FREE      = 2'd0,
    BUF_CAPTURING = 2'd1,
    BUF_READY     = 2'd2,
    BUF_READING   = 2'd3
  } buf_state_t;

  // Byte address of ring slot idx; wraps naturally at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] buf_addr(
    input logic [MAX_IDX_W-1:0] idx,
    input logic [ADDR_W-1:0]    base,
    input logic [ADDR_W-1:0]    stride
  );
    return base + ADDR_W'(idx) * stride;
  endfunction

endpackage

// File: rtl/frame_seq_ram.sv
// Per-slot frame sequence number store: one write port, one async read port.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the controller only writes on an accepted frame_done.
//
// Ports:
//   clk, reset        pixel clock, async active-low reset (clears all entries)
//   wr_en/wr_idx/wr_data  capture side write
//   rd_idx/rd_data    read side lookup
module frame_seq_ram
  import frame_buf_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [SEQ_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [SEQ_W-1:0] rd_data
);

  logic [SEQ_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/frame_buf_ctrl.sv
// Sequences image_if captures over a ring of frame buffers and hands finished frames to the host.
// Latency: trigger and grant are registered, one cycle after the enabling condition is sampled.
// Backpressure: with no free buffer no trigger issues (frames are skipped); grants wait for rd_req and a ready frame.
//
// Ports:
//   clk, reset                 pixel clock, async active-low reset
//   cap_enable, packing_mode_in   host capture controls
//   cap_trigger, cap_start_addr, cap_packing_mode   to image_if
//   cap_frame_done, cap_skipped   from image_if
//   rd_req, rd_done            host readout handshake
//   rd_grant, rd_addr, rd_seq  granted frame
//   frames_ready, frames_missed, spurious_done   status
module frame_buf_ctrl
  import frame_buf_ctrl_pkg::*;
#(
  parameter int               NUM_BUFFERS   = 4,   // legal 2..MAX_BUFFERS
  parameter logic [ADDR_W-1:0] BUF_BASE_ADDR = 30'h0000_0000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE    = 30'h0080_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_enable,
  input  logic              packing_mode_in,
  output logic              cap_trigger,
  output logic [ADDR_W-1:0] cap_start_addr,
  output logic              cap_packing_mode,
  input  logic              cap_frame_done,
  input  logic              cap_skipped,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [SEQ_W-1:0]  rd_seq,
  input  logic              rd_done,
  output logic [3:0]        frames_ready,
  output logic [15:0]       frames_missed,
  output logic              spurious_done
);

  localparam int IDX_W = $clog2(NUM_BUFFERS);

  logic [0:0]       cap_state;
  logic [0:0]       rd_state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [SEQ_W-1:0] cap_seq;
  logic [SEQ_W-1:0] seq_rd;

  logic       capturing;
  logic       reading;
  logic [4:0] free_cnt;
  logic       cap_go;
  logic       frame_acc;
  logic       rd_go;

  // Ring indices wrap at NUM_BUFFERS, which need not be a power of two.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_BUFFERS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign capturing = (cap_state == S_CAPTURE);
  assign reading   = (rd_state == R_BUSY);

  // Never negative: the ring has no holes, so the owned slots never exceed NUM_BUFFERS.
  assign free_cnt = 5'(NUM_BUFFERS) - {1'b0, frames_ready} - 5'(reading) - 5'(capturing);

  assign cap_go    = (cap_state == S_IDLE) && cap_enable && (free_cnt != 5'd0);
  assign frame_acc = capturing && cap_frame_done;
  // Uses registered frames_ready, so a frame completing this cycle is grantable next cycle.
  assign rd_go     = (rd_state == R_IDLE) && rd_req && (frames_ready != 4'd0);

  frame_seq_ram #(
    .DEPTH (NUM_BUFFERS),
    .IDX_W (IDX_W)
  ) u_seq_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (frame_acc),
    .wr_idx  (wr_idx),
    .wr_data (cap_seq),
    .rd_idx  (rd_idx),
    .rd_data (seq_rd)
  );

  // Capture side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_state        <= S_IDLE;
      cap_trigger      <= 1'b0;
      cap_start_addr   <= '0;
      cap_packing_mode <= 1'b0;
      wr_idx           <= '0;
      cap_seq          <= '0;
    end else begin
      cap_trigger <= 1'b0;
      case (cap_state)
        S_IDLE: begin
          if (cap_go) begin
            cap_trigger      <= 1'b1;
            cap_start_addr   <= buf_addr(MAX_IDX_W'(wr_idx), BUF_BASE_ADDR, BUF_STRIDE);
            cap_packing_mode <= packing_mode_in;
            cap_state        <= S_CAPTURE;
          end
        end
        default: begin
          // cap_enable is not looked at here: a started frame always finishes.
          if (cap_frame_done) begin
            cap_seq   <= cap_seq + SEQ_W'(1);
            wr_idx    <= idx_next(wr_idx);
            cap_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Read side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= R_IDLE;
      rd_grant <= 1'b0;
      rd_addr  <= '0;
      rd_seq   <= '0;
      rd_idx   <= '0;
    end else begin
      rd_grant <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (rd_go) begin
            rd_grant <= 1'b1;
            rd_addr  <= buf_addr(MAX_IDX_W'(rd_idx), BUF_BASE_ADDR, BUF_STRIDE);
            rd_seq   <= seq_rd;
            rd_idx   <= idx_next(rd_idx);
            rd_state <= R_BUSY;
          end
        end
        default: begin
          if (rd_done) begin
            rd_state <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Status counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_ready  <= '0;
      frames_missed <= '0;
      spurious_done <= 1'b0;
    end else begin
      // A completion and a grant in the same cycle cancel out.
      case ({frame_acc, rd_go})
        2'b10:   frames_ready <= frames_ready + 4'd1;
        2'b01:   frames_ready <= frames_ready - 4'd1;
        default: frames_ready <= frames_ready;
      endcase
      if (cap_skipped && (frames_missed != 16'hFFFF)) begin
        frames_missed <= frames_missed + 16'd1;
      end
      if (cap_frame_done && !capturing) begin
        spurious_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
module tb_frame_buf_ctrl;

  localparam int          NB     = 4;
  localparam logic [29:0] BASE   = 30'h0000_0000;
  localparam logic [29:0] STRIDE = 30'h0080_0000;

  logic        clk;
  logic        reset;
  logic        cap_enable;
  logic        packing_mode_in;
  logic        cap_trigger;
  logic [29:0] cap_start_addr;
  logic        cap_packing_mode;
  logic        cap_frame_done;
  logic        cap_skipped;
  logic        rd_req;
  logic        rd_grant;
  logic [29:0] rd_addr;
  logic [15:0] rd_seq;
  logic        rd_done;
  logic [3:0]  frames_ready;
  logic [15:0] frames_missed;
  logic        spurious_done;

  frame_buf_ctrl #(
    .NUM_BUFFERS   (NB),
    .BUF_BASE_ADDR (BASE),
    .BUF_STRIDE    (STRIDE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cap_enable       (cap_enable),
    .packing_mode_in  (packing_mode_in),
    .cap_trigger      (cap_trigger),
    .cap_start_addr   (cap_start_addr),
    .cap_packing_mode (cap_packing_mode),
    .cap_frame_done   (cap_frame_done),
    .cap_skipped      (cap_skipped),
    .rd_req           (rd_req),
    .rd_grant         (rd_grant),
    .rd_addr          (rd_addr),
    .rd_seq           (rd_seq),
    .rd_done          (rd_done),
    .frames_ready     (frames_ready),
    .frames_missed    (frames_missed),
    .spurious_done    (spurious_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [29:0] addr;
    logic [15:0] seq;
  } frm_t;

  frm_t        ready_q[$];
  int          m_done_cnt;   // frames completed since reset
  bit          m_capturing;
  bit          m_reading;
  logic        e_trig;
  logic [29:0] e_addr;
  logic        e_pack;
  logic        e_grant;
  logic [29:0] e_raddr;
  logic [15:0] e_rseq;
  logic [15:0] e_missed;
  logic        e_spur;

  function automatic logic [29:0] slot_addr(input int s);
    return BASE + 30'(s) * STRIDE;
  endfunction

  task automatic model_clear();
    ready_q.delete();
    m_done_cnt  = 0;
    m_capturing = 0;
    m_reading   = 0;
    e_trig      = 0;
    e_addr      = '0;
    e_pack      = 0;
    e_grant     = 0;
    e_raddr     = '0;
    e_rseq      = '0;
    e_missed    = '0;
    e_spur      = 0;
  endtask

  // Evaluated at each rising edge with the inputs the DUT samples there.
  task automatic model_update();
    int   free;
    bit   start;
    bit   grant;
    frm_t f;
    if (!reset) begin
      model_clear();
      return;
    end
    free    = NB - ready_q.size() - int'(m_reading) - int'(m_capturing);
    e_trig  = 0;
    e_grant = 0;
    start   = !m_capturing && cap_enable && (free > 0);
    if (start) begin
      e_trig = 1;
      e_addr = slot_addr(m_done_cnt % NB);
      e_pack = packing_mode_in;
    end
    if (!m_capturing && cap_frame_done) e_spur = 1;
    grant = !m_reading && rd_req && (ready_q.size() > 0);
    if (grant) begin
      f       = ready_q.pop_front();
      e_grant = 1;
      e_raddr = f.addr;
      e_rseq  = f.seq;
    end
    if (m_capturing && cap_frame_done) begin
      f.addr = slot_addr(m_done_cnt % NB);
      f.seq  = 16'(m_done_cnt);
      ready_q.push_back(f);
      m_done_cnt++;
      m_capturing = 0;
    end else if (start) begin
      m_capturing = 1;
    end
    if (grant) m_reading = 1;
    else if (m_reading && rd_done) m_reading = 0;
    if (cap_skipped && e_missed != 16'hFFFF) e_missed = e_missed + 16'd1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_cap_trigger",   32'(cap_trigger),      32'(e_trig));
    chk("m_cap_addr",      32'(cap_start_addr),   32'(e_addr));
    chk("m_cap_pack",      32'(cap_packing_mode), 32'(e_pack));
    chk("m_rd_grant",      32'(rd_grant),         32'(e_grant));
    chk("m_rd_addr",       32'(rd_addr),          32'(e_raddr));
    chk("m_rd_seq",        32'(rd_seq),           32'(e_rseq));
    chk("m_frames_ready",  32'(frames_ready),     32'(ready_q.size()));
    chk("m_frames_missed", 32'(frames_missed),    32'(e_missed));
    chk("m_spurious",      32'(spurious_done),    32'(e_spur));
  endtask

  // Every cycle passes through here: compare mid-cycle, then advance the model at the edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_trig(input string nm);
    int i;
    i = 0;
    while (cap_trigger !== 1'b1 && i < 50) begin
      step();
      i++;
    end
    chk(nm, 32'(cap_trigger), 32'd1);
  endtask

  task automatic pulse_done();
    cap_frame_done = 1'b1;
    step();
    cap_frame_done = 1'b0;
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  task automatic request_read();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic count_triggers(input int n, output int nt);
    nt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cap_trigger === 1'b1) nt++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nt;
    n_cmp = 0;
    n_err = 0;
    reset           = 1'b0;
    cap_enable      = 1'b0;
    packing_mode_in = 1'b0;
    cap_frame_done  = 1'b0;
    cap_skipped     = 1'b0;
    rd_req          = 1'b0;
    rd_done         = 1'b0;
    model_clear();
    steps(3);
    reset = 1'b1;

    // reset values
    chk("rst_trigger", 32'(cap_trigger),    32'd0);
    chk("rst_addr",    32'(cap_start_addr), 32'd0);
    chk("rst_ready",   32'(frames_ready),   32'd0);
    chk("rst_missed",  32'(frames_missed),  32'd0);
    chk("rst_spur",    32'(spurious_done),  32'd0);
    chk("rst_grant",   32'(rd_grant),       32'd0);

    // first trigger one cycle after enable
    cap_enable      = 1'b1;
    packing_mode_in = 1'b1;
    step();
    chk("first_trig", 32'(cap_trigger),      32'd1);
    chk("first_addr", 32'(cap_start_addr),   32'h0000000);
    chk("first_pack", 32'(cap_packing_mode), 32'd1);

    // fill the ring
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_trig("fill_trig");
        chk("fill_addr", 32'(cap_start_addr), 32'(i) * 32'h0080_0000);
      end
      pulse_done();
    end
    steps(3);
    chk("full_ready", 32'(frames_ready), 32'd4);
    chk("full_trig",  32'(cap_trigger),  32'd0);

    // skipped frames while full
    for (int i = 0; i < 3; i++) begin
      cap_skipped = 1'b1;
      step();
      cap_skipped = 1'b0;
      step();
    end
    chk("missed_3", 32'(frames_missed), 32'd3);
    count_triggers(20, nt);
    chk("no_5th_trig", 32'(nt), 32'd0);

    // first read, then exactly one refill into slot 0
    request_read();
    chk("rd1_grant", 32'(rd_grant),     32'd1);
    chk("rd1_addr",  32'(rd_addr),      32'h0000000);
    chk("rd1_seq",   32'(rd_seq),       32'd0);
    chk("rd1_ready", 32'(frames_ready), 32'd3);
    step();
    pulse_rd_done();
    wait_trig("refill_trig");
    chk("refill_addr", 32'(cap_start_addr), 32'h0000000);
    count_triggers(20, nt);
    chk("one_refill", 32'(nt), 32'd0);

    // second read brings frames_ready to 2
    request_read();
    chk("rd2_seq", 32'(rd_seq), 32'd1);
    pulse_rd_done();

    // simultaneous frame_done and grant
    rd_req         = 1'b1;
    cap_frame_done = 1'b1;
    step();
    rd_req         = 1'b0;
    cap_frame_done = 1'b0;
    chk("sim_grant", 32'(rd_grant),     32'd1);
    chk("sim_addr",  32'(rd_addr),      32'h1000000);
    chk("sim_seq",   32'(rd_seq),       32'd2);
    chk("sim_ready", 32'(frames_ready), 32'd2);
    wait_trig("sim_wr_trig");
    chk("sim_wr_addr", 32'(cap_start_addr), 32'h0800000);
    pulse_rd_done();
    request_read();
    chk("sim_rd_addr", 32'(rd_addr), 32'h1800000);
    chk("sim_rd_seq",  32'(rd_seq),  32'd3);
    pulse_rd_done();
    request_read();
    chk("wrap_addr", 32'(rd_addr), 32'h0000000);
    chk("wrap_seq",  32'(rd_seq),  32'd4);
    pulse_rd_done();

    // enable dropped mid-capture
    cap_enable = 1'b0;
    steps(5);
    pulse_done();
    chk("drop_ready", 32'(frames_ready), 32'd1);
    count_triggers(100, nt);
    chk("drop_no_trig", 32'(nt), 32'd0);

    // spurious frame_done while idle
    chk("spur_before", 32'(spurious_done), 32'd0);
    pulse_done();
    chk("spur_set",   32'(spurious_done), 32'd1);
    chk("spur_ready", 32'(frames_ready),  32'd1);

    // reset in the middle of a capture
    cap_enable = 1'b1;
    wait_trig("pre_rst_trig");
    chk("pre_rst_addr", 32'(cap_start_addr), 32'h1000000);
    steps(2);
    reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_addr",  32'(cap_start_addr),   32'd0);
    chk("mid_rst_pack",  32'(cap_packing_mode), 32'd0);
    chk("mid_rst_ready", 32'(frames_ready),     32'd0);
    chk("mid_rst_spur",  32'(spurious_done),    32'd0);
    chk("mid_rst_miss",  32'(frames_missed),    32'd0);
    chk("mid_rst_raddr", 32'(rd_addr),          32'd0);
    steps(2);
    reset = 1'b1;
    step();
    chk("post_rst_trig", 32'(cap_trigger),    32'd1);
    chk("post_rst_addr", 32'(cap_start_addr), 32'h0000000);
    pulse_done();
    request_read();
    chk("post_rst_grant", 32'(rd_grant), 32'd1);
    chk("post_rst_seq",   32'(rd_seq),   32'd0);
    pulse_rd_done();
    cap_enable = 1'b0;
    steps(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
Sequences the pixel-capture datapath (image_if) over a ring of NUM_BUFFERS frame buffers in DDR, and hands completed frames to the host readout path.
- Issues the capture trigger, start address and packing mode.
- Tracks buffer ownership: free, capturing, ready, reading.
- Keeps per-frame sequence numbers and counts missed frames.
- Sits in the pixel clock domain between host control registers and image_if.

Parameters:
NUM_BUFFERS, 4, number of ring buffers; legal range 2..8.
BUF_BASE_ADDR, 30'h0000_0000, byte address of buffer 0.
BUF_STRIDE, 30'h0080_0000, byte distance between consecutive buffers.

Ports:
clk  in  1  pixel clock.
reset  in  1  asynchronous, active-low reset.
cap_enable  in  1  level; continuous capture while high.
packing_mode_in  in  1  host packing select (0 = 8bpp, 1 = 16bpp).
cap_trigger  out  1  one-cycle pulse to image_if trigger.
cap_start_addr  out  30  buffer byte address; valid in the same cycle as cap_trigger.
cap_packing_mode  out  1  packing mode latched at trigger.
cap_frame_done  in  1  image_if frame_done pulse.
cap_skipped  in  1  image_if skipped pulse.
rd_req  in  1  level; host wants the next ready frame.
rd_grant  out  1  one-cycle pulse; a frame is handed to the host.
rd_addr  out  30  byte address of the granted buffer; held until the next grant.
rd_seq  out  16  sequence number of the granted frame.
rd_done  in  1  pulse; host has finished the granted frame.
frames_ready  out  4  count of completed, unread frames.
frames_missed  out  16  saturating count of cap_skipped pulses.
spurious_done  out  1  sticky; set when frame_done arrives outside S_CAPTURE.

Behaviour:
- Reset values: all outputs 0. Internal state cleared: wr_idx=0, rd_idx=0, reading=0, cap_seq=0, capture FSM in S_IDLE. image_if is held in reset by the same source.
- Indices are $clog2(NUM_BUFFERS) bits wide and wrap modulo NUM_BUFFERS.
- Buffer address = BUF_BASE_ADDR + idx*BUF_STRIDE, truncated to 30 bits.
- Occupancy: free = NUM_BUFFERS - frames_ready - reading - capturing, where capturing = (state==S_CAPTURE). All terms are registered values.
- Capture FSM:
  - S_IDLE: if cap_enable && free>0, then next cycle cap_trigger=1, cap_start_addr=addr(wr_idx), cap_packing_mode=packing_mode_in; go to S_CAPTURE.
  - S_CAPTURE: on cap_frame_done, store seq[wr_idx]=cap_seq, then cap_seq++, wr_idx++, frames_ready++; go to S_IDLE. A new trigger may issue no earlier than the cycle after return to S_IDLE.
  - cap_enable falling during S_CAPTURE: the current frame completes normally; no further trigger.
  - cap_frame_done in S_IDLE: ignored except that it sets spurious_done.
  - cap_start_addr and cap_packing_mode hold their values between triggers.
- Read FSM:
  - R_IDLE: if rd_req && frames_ready>0 (registered), then next cycle rd_grant=1, rd_addr=addr(rd_idx), rd_seq=seq[rd_idx]; rd_idx++, frames_ready--, reading=1; go to R_BUSY.
  - R_BUSY: on rd_done, reading=0; go to R_IDLE. rd_req is ignored in R_BUSY.
  - rd_done in R_IDLE is ignored.
- Simultaneous frame_done and read grant in one cycle: frames_ready net change is 0.
- A frame completing in cycle N is visible to the grant logic at N+1.
- No overwrite: with free==0, no trigger issues; frames passing meanwhile arrive as cap_skipped and increment frames_missed.
- frames_missed saturates at 16'hFFFF.
- Ownership invariant: the reading buffer is rd_idx-1, ready buffers are rd_idx..rd_idx+frames_ready-1, and wr_idx = rd_idx+frames_ready. No holes in the ring.

Decomposition:
- Shared package: buffer-state and FSM state encodings, MAX_BUFFERS=8, ADDR_W=30, SEQ_W=16.
- One natural sub-module: frame_seq_ram, a NUM_BUFFERS x 16 register file with 1 write port (capture side) and 1 asynchronous read port (read side).
- Capture and read FSMs live in the top module.

Test Plan:
- Reset, cap_enable=1, packing_mode_in=1 -> first cap_trigger 1 cycle later with cap_start_addr=0x0000000 and cap_packing_mode=1; after cap_frame_done, the second trigger carries 0x0800000.
- Capture 4 frames with no reads -> frames_ready=4, no 5th trigger; 3 cap_skipped pulses -> frames_missed=3.
- With frames_ready=4, assert rd_req -> rd_grant with rd_addr=0x0000000 and rd_seq=0, frames_ready=3; rd_done -> exactly one new trigger at 0x0000000.
- cap_frame_done and rd_grant in the same cycle with frames_ready=2 -> frames_ready stays 2; wr_idx and rd_idx both advance.
- cap_enable dropped mid-capture -> that frame completes, frames_ready increments, no further cap_trigger for 100 cycles.
- cap_frame_done while in S_IDLE -> spurious_done=1 and frames_ready unchanged; reset asserted mid-capture -> all outputs 0, next trigger goes to address 0x0000000 with seq restarting at 0.
